// File: rtl/serial_frame_tx_pkg.sv
// Shared types and defaults for the serial frame transmitter.
// State encoding is fixed at 3 bits so debug taps stay stable across widths.
package serial_frame_tx_pkg;

  localparam int DFLT_PORT_W = 2;
  localparam int DFLT_CNT_W  = 4;
  localparam int DFLT_DATA_W = 15;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PORT  = 3'd2,
    NUM   = 3'd3,
    DATA  = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == START) || (s == PORT) || (s == NUM) || (s == DATA);
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request/line bundle between a frame requester and serial_frame_tx.
// master drives the request and watches the line; slave is the transmitter.
interface serial_frame_tx_if
  import serial_frame_tx_pkg::*;
#(
  parameter int PORT_W = DFLT_PORT_W,
  parameter int CNT_W  = DFLT_CNT_W,
  parameter int DATA_W = DFLT_DATA_W
);
  logic              start;
  logic [PORT_W-1:0] portIn;
  logic [CNT_W-1:0]  numIn;
  logic [DATA_W-1:0] dataIn;
  logic              serOut;
  logic              busy;
  logic              done;

  modport master (output start, portIn, numIn, dataIn, input serOut, busy, done);
  modport slave  (input start, portIn, numIn, dataIn, output serOut, busy, done);
endinterface

// File: rtl/tx_bit_cnt.sv
// Loadable down-counter marking the last tick of each frame field.
// Latency: zero reflects the count one clkEn tick after ld/dec; holds at zero.
module tx_bit_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             ld,
  input  logic             dec,
  input  logic [CNT_W-1:0] ld_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clkEn) begin
      if (ld) begin
        cnt <= ld_val;
      end else if (dec && !zero) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serialises start bit, port (MSB first), length (MSB first), payload (LSB first).
// Latency: start bit one clkEn tick after accept; no backpressure, start ignored unless IDLE.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int PORT_W = DFLT_PORT_W,
  parameter int CNT_W  = DFLT_CNT_W,
  parameter int DATA_W = DFLT_DATA_W
) (
  input logic              clk,
  input logic              rst,
  input logic              clkEn,
  serial_frame_tx_if.slave req
);

  localparam int HDR_W = PORT_W + CNT_W;

  state_t            state, state_nxt;
  logic [HDR_W-1:0]  hdr, hdr_nxt;
  logic [DATA_W-1:0] pay, pay_nxt;
  logic [CNT_W-1:0]  num;
  logic              ser, ser_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              accept;
  logic              cnt_ld, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;

  assign accept = (state == IDLE) && req.start;

  tx_bit_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clkEn  (clkEn),
    .ld     (cnt_ld),
    .dec    (cnt_dec),
    .ld_val (cnt_val),
    .zero   (cnt_zero)
  );

  // Outputs are flopped alongside the state so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hdr    <= '0;
      pay    <= '0;
      num    <= '0;
      ser    <= IDLE_LEVEL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (clkEn) begin
      state  <= state_nxt;
      hdr    <= hdr_nxt;
      pay    <= pay_nxt;
      ser    <= ser_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (accept) begin
        num <= req.numIn;
      end
    end
  end

  // The counter is loaded with (field length - 1) on the tick before each field.
  always_comb begin
    state_nxt = state;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    case (state)
      IDLE:  if (req.start) state_nxt = START;
      START: begin
        state_nxt = PORT;
        cnt_ld    = 1'b1;
        cnt_val   = CNT_W'(PORT_W - 1);
      end
      PORT: begin
        if (cnt_zero) begin
          state_nxt = NUM;
          cnt_ld    = 1'b1;
          cnt_val   = CNT_W'(CNT_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      NUM: begin
        if (cnt_zero) begin
          if (num != '0) begin
            state_nxt = DATA;
            cnt_ld    = 1'b1;
            cnt_val   = num - 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DATA: begin
        if (cnt_zero) state_nxt = DONE;
        else          cnt_dec   = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hdr_nxt = hdr;
    pay_nxt = pay;
    if (accept) begin
      hdr_nxt = {req.portIn, req.numIn};
      pay_nxt = req.dataIn;
    end else if ((state == PORT) || (state == NUM)) begin
      hdr_nxt = {hdr[HDR_W-2:0], 1'b0};
    end else if (state == DATA) begin
      pay_nxt = {1'b0, pay[DATA_W-1:1]};
    end

    case (state_nxt)
      START:     ser_nxt = ~IDLE_LEVEL;
      PORT, NUM: ser_nxt = hdr_nxt[HDR_W-1];
      DATA:      ser_nxt = pay_nxt[0];
      default:   ser_nxt = IDLE_LEVEL;
    endcase

    busy_nxt = is_busy(state_nxt);
    done_nxt = (state_nxt == DONE);
  end

  assign req.serOut = ser;
  assign req.busy   = busy_q;
  assign req.done   = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: frames expected at request time are queued and
// compared against the bits collected from the line while busy.
module tb_serial_frame_tx;

  typedef struct {
    int          len;
    logic [31:0] bits;
  } exp_t;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic clkEn   = 1'b0;
  logic clk_run = 1'b0;
  int   en_period = 1;
  int   phase     = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  serial_frame_tx_if bus ();

  serial_frame_tx dut (
    .clk   (clk),
    .rst   (rst),
    .clkEn (clkEn),
    .req   (bus)
  );

  always #5 if (clk_run) clk = ~clk;

  always @(negedge clk) begin
    phase = (phase + 1) % en_period;
    clkEn = (phase == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d);
    exp_t e;
    e.bits = '0;
    e.len  = 1;
    for (int i = 1; i >= 0; i--) begin e.bits[e.len] = p[i]; e.len++; end
    for (int i = 3; i >= 0; i--) begin e.bits[e.len] = n[i]; e.len++; end
    for (int i = 0; i < int'(n); i++) begin e.bits[e.len] = d[i]; e.len++; end
    return e;
  endfunction

  // Line monitor: collects bits on clkEn ticks while busy, scores on done.
  logic        tick = 1'b0;
  int          cur_len = 0;
  logic [31:0] cur_bits = '0;
  logic        prev_done = 1'b0;
  logic        last_ser = 1'b1, last_busy = 1'b0, last_done = 1'b0;

  always @(posedge clk) tick <= clkEn;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_len   = 0;
      cur_bits  = '0;
      prev_done = 1'b0;
    end else if (tick) begin
      if (prev_done) begin
        check("done_one_tick", bus.done, 1'b0);
        check("gap_idle", bus.busy, 1'b0);
      end
      if (bus.busy) begin
        if (cur_len < 32) cur_bits[cur_len] = bus.serOut;
        cur_len++;
      end else if (bus.done) begin
        check("done_line_high", bus.serOut, 1'b1);
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check("frame_len", cur_len, e.len);
          check("frame_bits", cur_bits, e.bits);
        end
        cur_len  = 0;
        cur_bits = '0;
      end else begin
        check("idle_line_high", bus.serOut, 1'b1);
      end
      prev_done = bus.done;
    end else begin
      check("hold_ser", bus.serOut, last_ser);
      check("hold_busy", bus.busy, last_busy);
      check("hold_done", bus.done, last_done);
    end
    last_ser  = bus.serOut;
    last_busy = bus.busy;
    last_done = bus.done;
  end

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (bus.busy || bus.done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_accept();
    int w = 0;
    do begin
      @(posedge clk);
      w++;
    end while (!clkEn && w < 20);
    if (!clkEn) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_exp(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d,
                          input exp_t e);
    wait_idle();
    bus.portIn = p;
    bus.numIn  = n;
    bus.dataIn = d;
    bus.start  = 1'b1;
    sb.push_back(e);
    wait_accept();
    bus.portIn = 2'($urandom);
    bus.numIn  = 4'($urandom);
    bus.dataIn = 15'($urandom);
  endtask

  task automatic send(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d);
    send_exp(p, n, d, model(p, n, d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    bus.start  = 1'b0;
    bus.portIn = '0;
    bus.numIn  = '0;
    bus.dataIn = '0;

    // Asynchronous reset with the clock stopped
    #2 rst = 1'b1;
    #1;
    check("rst_ser", bus.serOut, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    en_period = 1;
    send_exp(2'd2, 4'd3, 15'b101, '{len: 10, bits: 32'b10_1110_0010});
    send_exp(2'd3, 4'd0, 15'h7FFF, '{len: 7, bits: 32'b000_0110});

    en_period = 4;
    send_exp(2'd2, 4'd3, 15'b101, '{len: 10, bits: 32'b10_1110_0010});
    send(2'd1, 4'd15, 15'h4C35);

    // Start held with new inputs mid-frame: current frame intact, next begins from IDLE
    en_period = 1;
    send(2'd2, 4'd3, 15'h0005);
    repeat (3) @(negedge clk);
    bus.portIn = 2'd1;
    bus.numIn  = 4'd5;
    bus.dataIn = 15'h2AB;
    bus.start  = 1'b1;
    sb.push_back(model(2'd1, 4'd5, 15'h2AB));
    wait_idle();
    wait_accept();

    // Reset during the payload of a 15-bit frame
    send(2'd1, 4'd15, 15'h5A3C);
    repeat (9) @(negedge clk);
    #2;
    check("mid_frame_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_ser", bus.serOut, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    void'(sb.pop_front());
    send(2'd2, 4'd15, 15'h7FFF);

    for (int i = 0; i < 8; i++) begin
      en_period = $urandom_range(1, 3);
      send(2'($urandom), 4'($urandom), 15'($urandom));
    end

    w = 0;
    while ((sb.size() != 0 || bus.busy || bus.done) && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
